// File: rtl/hier_fifo_mc_pkg.sv
// Shared definitions for the multi-channel hierarchical FIFO.
package hier_fifo_mc_pkg;

  // Watermark percentages above this value saturate to it.
  localparam int unsigned WM_MAX = 100;

  // Default configuration widths.
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_CH_W       = $clog2(DEF_NUM_CH);

  // L2 entry layout {ch, data} for the default configuration; the top rebuilds
  // the same layout from its own parameters.
  typedef struct packed {
    logic [DEF_CH_W-1:0]       ch;
    logic [DEF_DATA_WIDTH-1:0] data;
  } l2_entry_t;

  // True when count/depth >= wm percent, with wm clamped to WM_MAX.
  function automatic logic wm_hit(input logic [31:0] count,
                                  input logic [31:0] depth,
                                  input logic [6:0]  wm);
    logic [31:0] wm_c;
    wm_c = (32'(wm) > WM_MAX) ? WM_MAX : 32'(wm);
    return (count * 32'd100) >= (wm_c * depth);
  endfunction

endpackage

// File: rtl/hier_fifo_mc_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are invalidated by the pointer reset alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/hier_fifo_mc.sv
// NUM_CH private L1 FIFOs promoted round-robin into one tagged L2 FIFO.
module hier_fifo_mc
  import hier_fifo_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned L1_DEPTH   = 16,
  parameter int unsigned L2_DEPTH   = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_CH-1:0]              wr_full,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [$clog2(NUM_CH)-1:0]      rd_ch,
  output logic                           rd_empty,
  input  logic [6:0]                     watermark,
  output logic                           backpressure,
  output logic [NUM_CH-1:0]              l1_overflow,
  input  logic                           clr_ovf,
  output logic [$clog2(L2_DEPTH):0]      l2_count
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned L1_CW = $clog2(L1_DEPTH) + 1;
  localparam int unsigned L2_CW = $clog2(L2_DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_CH-1:0]     w_l1_push;
  logic [NUM_CH-1:0]     w_l1_pop;
  logic [NUM_CH-1:0]     w_l1_full;
  logic [NUM_CH-1:0]     w_l1_empty;
  logic [DATA_WIDTH-1:0] w_l1_head [NUM_CH];
  logic [L1_CW-1:0]      w_l1_cnt_unused [NUM_CH];

  logic                  w_grant_vld;
  logic [CH_W-1:0]       w_grant_ch;
  logic [CH_W-1:0]       w_idx;
  logic [CH_W-1:0]       r_last_grant;

  entry_t                w_l2_in;
  entry_t                w_l2_head;
  logic                  w_l2_full;
  logic                  w_l2_empty;
  logic                  w_l2_pop;
  logic [L2_CW-1:0]      w_l2_count_next;

  logic                  r_bp;
  logic [NUM_CH-1:0]     r_ovf;

  // Per-channel L1 FIFOs; a write into a full L1 is dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_l1
    assign w_l1_push[c] = wr_en[c] & ~w_l1_full[c];
    assign w_l1_pop[c]  = w_grant_vld & (w_grant_ch == CH_W'(c));

    sync_fifo_fwft #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (L1_DEPTH)
    ) u_l1 (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_l1_push[c]),
      .i_push_data (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_pop       (w_l1_pop[c]),
      .o_pop_data  (w_l1_head[c]),
      .o_full      (w_l1_full[c]),
      .o_empty     (w_l1_empty[c]),
      .o_count     (w_l1_cnt_unused[c])
    );
  end

  // Round-robin search starting one past the last granted channel; no grant
  // while L2 is full, even if the read port pops this cycle.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_idx       = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      w_idx = CH_W'((32'(r_last_grant) + i) % NUM_CH);
      if (!w_grant_vld && !w_l2_full && !w_l1_empty[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_idx;
      end
    end
  end

  // Remember the last grant so the next search starts after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_ch;
    end
  end

  assign w_l2_in.ch   = w_grant_ch;
  assign w_l2_in.data = w_l1_head[w_grant_ch];
  assign w_l2_pop     = rd_en & ~w_l2_empty;

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH + CH_W),
    .DEPTH (L2_DEPTH)
  ) u_l2 (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_grant_vld),
    .i_push_data (w_l2_in),
    .i_pop       (w_l2_pop),
    .o_pop_data  (w_l2_head),
    .o_full      (w_l2_full),
    .o_empty     (w_l2_empty),
    .o_count     (l2_count)
  );

  assign w_l2_count_next = l2_count + L2_CW'(w_grant_vld) - L2_CW'(w_l2_pop);

  // Backpressure tracks post-edge occupancy; overflow flags are sticky and a
  // new overflow outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bp  <= 1'b0;
      r_ovf <= '0;
    end else begin
      r_bp  <= wm_hit(32'(w_l2_count_next), 32'(L2_DEPTH), watermark);
      r_ovf <= (clr_ovf ? '0 : r_ovf) | (wr_en & w_l1_full);
    end
  end

  assign wr_full      = w_l1_full;
  assign rd_data      = w_l2_head.data;
  assign rd_ch        = w_l2_head.ch;
  assign rd_empty     = w_l2_empty;
  assign backpressure = r_bp;
  assign l1_overflow  = r_ovf;

endmodule

// File: tb/tb_hier_fifo_mc.sv
// Self-checking bench for hier_fifo_mc against a queue-based reference model.
module tb_hier_fifo_mc;

  localparam int NCH = 4;
  localparam int L1D = 16;
  localparam int L2D = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_en;
  logic [63:0] wr_data;
  logic [3:0]  wr_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [1:0]  rd_ch;
  logic        rd_empty;
  logic [6:0]  watermark;
  logic        backpressure;
  logic [3:0]  l1_overflow;
  logic        clr_ovf;
  logic [7:0]  l2_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queues per channel plus one tagged L2 queue.
  int         m_l1 [NCH][$];
  int         m_l2 [$];
  int         m_last;
  logic [3:0] m_ovf;
  logic       m_bp;

  hier_fifo_mc u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_ch        (rd_ch),
    .rd_empty     (rd_empty),
    .watermark    (watermark),
    .backpressure (backpressure),
    .l1_overflow  (l1_overflow),
    .clr_ovf      (clr_ovf),
    .l2_count     (l2_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_l1[c].delete();
    m_l2.delete();
    m_last = NCH - 1;
    m_ovf  = '0;
    m_bp   = 1'b0;
  endtask

  function automatic int m_total();
    int t = m_l2.size();
    for (int c = 0; c < NCH; c++) t += m_l1[c].size();
    return t;
  endfunction

  function automatic logic [15:0] m_head_data();
    return (m_l2.size() > 0) ? 16'(m_l2[0] & 16'hFFFF) : 16'h0;
  endfunction

  function automatic logic [1:0] m_head_ch();
    return (m_l2.size() > 0) ? 2'(m_l2[0] >>> 16) : 2'd0;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    for (int c = 0; c < NCH; c++) f[c] = (m_l1[c].size() == L1D);
    return f;
  endfunction

  // Drive one clock of stimulus and advance the model by the same edge.
  task automatic cycle(input logic [3:0] we, input logic [63:0] wd,
                       input logic re, input logic clr);
    bit         pop;
    int         grant;
    int         cc;
    int         wmc;
    logic [3:0] full_pre;
    logic [3:0] set;
    wr_en = we; wr_data = wd; rd_en = re; clr_ovf = clr;
    pop   = re && (m_l2.size() > 0);
    grant = -1;
    if (m_l2.size() < L2D)
      for (int i = 1; i <= NCH; i++) begin
        cc = (m_last + i) % NCH;
        if (grant < 0 && m_l1[cc].size() > 0) grant = cc;
      end
    full_pre = m_full();
    if (pop) void'(m_l2.pop_front());
    if (grant >= 0) begin
      m_l2.push_back((grant << 16) | m_l1[grant].pop_front());
      m_last = grant;
    end
    set = '0;
    for (int c = 0; c < NCH; c++)
      if (we[c]) begin
        if (full_pre[c]) set[c] = 1'b1;
        else m_l1[c].push_back(int'(wd[c*16 +: 16]));
      end
    m_ovf = (clr ? 4'b0 : m_ovf) | set;
    wmc   = (int'(watermark) > 100) ? 100 : int'(watermark);
    m_bp  = (m_l2.size() * 100) >= (wmc * L2D);
    @(posedge clk); #1;
    wr_en = '0; rd_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic apply_reset();
    wr_en = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = '0; wr_data = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    watermark = 7'd75;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    n_tests++; if (wr_full !== 4'b0)      begin n_fail++; $display("FAIL reset_wr_full: got %b expected 0000", wr_full); end
    n_tests++; if (rd_empty !== 1'b1)     begin n_fail++; $display("FAIL reset_rd_empty: got %b expected 1", rd_empty); end
    n_tests++; if (rd_data !== 16'h0)     begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    n_tests++; if (rd_ch !== 2'd0)        begin n_fail++; $display("FAIL reset_rd_ch: got %0d expected 0", rd_ch); end
    n_tests++; if (backpressure !== 1'b0) begin n_fail++; $display("FAIL reset_bp: got %b expected 0", backpressure); end
    n_tests++; if (l1_overflow !== 4'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", l1_overflow); end
    n_tests++; if (l2_count !== 8'd0)     begin n_fail++; $display("FAIL reset_l2_count: got %0d expected 0", l2_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(4'b0001, 64'(i), 1'b0, 1'b0);
    repeat (5) cycle(4'b0, 64'b0, 1'b0, 1'b0);
    n_tests++; if (l2_count !== 8'd20) begin n_fail++; $display("FAIL basic_count: got %0d expected 20", l2_count); end
    for (int i = 0; i < 20; i++) begin
      n_tests++; if (rd_empty !== 1'b0)   begin n_fail++; $display("FAIL basic_nonempty[%0d]: got %b expected 0", i, rd_empty); end
      n_tests++; if (rd_data !== 16'(i))  begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, rd_data, 16'(i)); end
      n_tests++; if (rd_ch !== 2'd0)      begin n_fail++; $display("FAIL basic_ch[%0d]: got %0d expected 0", i, rd_ch); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
    end
    n_tests++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_end: got %b expected 1", rd_empty); end
    n_tests++; if (l2_count !== 8'd0) begin n_fail++; $display("FAIL basic_count_end: got %0d expected 0", l2_count); end
    n_tests++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL basic_data_end: got %h expected 0000", rd_data); end
  endtask

  task automatic test_round_robin();
    logic [63:0] wd;
    logic [1:0]  ech;
    logic [15:0] ed;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      wd = {16'(16'h300 + k), 16'(16'h200 + k), 16'(16'h100 + k), 16'(k)};
      cycle(4'hF, wd, 1'b0, 1'b0);
    end
    repeat (16) cycle(4'b0, 64'b0, 1'b0, 1'b0);
    n_tests++; if (l2_count !== 8'd16) begin n_fail++; $display("FAIL rr_count: got %0d expected 16", l2_count); end
    for (int i = 0; i < 16; i++) begin
      ech = 2'(i % 4);
      ed  = 16'(int'(ech) * 256 + i / 4);
      n_tests++; if (rd_ch !== ech)  begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", i, rd_ch, ech); end
      n_tests++; if (rd_data !== ed) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, rd_data, ed); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_l2_full();
    int c;
    int nread;
    int guard;
    apply_reset();
    for (int i = 0; i < 144; i++) begin
      c = i % 4;
      cycle(4'(1 << c), 64'($urandom_range(0, 65535)) << (c * 16), 1'b0, 1'b0);
    end
    repeat (4) cycle(4'b0, 64'b0, 1'b0, 1'b0);
    n_tests++; if (l2_count !== 8'd128) begin n_fail++; $display("FAIL full_count: got %0d expected 128", l2_count); end
    n_tests++; if (wr_full !== 4'b0)    begin n_fail++; $display("FAIL full_l1_full: got %b expected 0000", wr_full); end
    nread = 0;
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (rd_data !== m_head_data()) begin n_fail++; $display("FAIL full_step_data[%0d]: got %h expected %h", i, rd_data, m_head_data()); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
      nread++;
      n_tests++; if (l2_count !== 8'd127) begin n_fail++; $display("FAIL full_after_read[%0d]: got %0d expected 127", i, l2_count); end
      cycle(4'b0, 64'b0, 1'b0, 1'b0);
      n_tests++; if (l2_count !== 8'd128) begin n_fail++; $display("FAIL full_refill[%0d]: got %0d expected 128", i, l2_count); end
    end
    guard = 0;
    while (m_total() > 0 && guard < 400) begin
      n_tests++; if (rd_data !== m_head_data() || rd_ch !== m_head_ch()) begin n_fail++; $display("FAIL full_drain[%0d]: got %0d/%h expected %0d/%h", nread, rd_ch, rd_data, m_head_ch(), m_head_data()); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
      nread++; guard++;
    end
    n_tests++; if (nread != 144) begin n_fail++; $display("FAIL full_total: got %0d expected 144", nread); end
    n_tests++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL full_empty_end: got %b expected 1", rd_empty); end
  endtask

  task automatic test_overflow();
    int c;
    int n2;
    int last2;
    int guard;
    apply_reset();
    for (int i = 0; i < 128; i++) begin
      c = i % 2;
      cycle(4'(1 << c), 64'($urandom_range(0, 65535)) << (c * 16), 1'b0, 1'b0);
    end
    repeat (2) cycle(4'b0, 64'b0, 1'b0, 1'b0);
    n_tests++; if (l2_count !== 8'd128) begin n_fail++; $display("FAIL ovf_stall: got %0d expected 128", l2_count); end
    for (int i = 0; i < 17; i++) begin
      cycle(4'b0100, 64'(16'h2000 + i) << 32, 1'b0, 1'b0);
      if (i == 15) begin
        n_tests++; if (wr_full !== 4'b0100)     begin n_fail++; $display("FAIL ovf_full16: got %b expected 0100", wr_full); end
        n_tests++; if (l1_overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_none16: got %b expected 0000", l1_overflow); end
      end
    end
    n_tests++; if (l1_overflow !== 4'b0100) begin n_fail++; $display("FAIL ovf_set: got %b expected 0100", l1_overflow); end
    n_tests++; if (wr_full !== 4'b0100)     begin n_fail++; $display("FAIL ovf_full17: got %b expected 0100", wr_full); end
    cycle(4'b0, 64'b0, 1'b0, 1'b1);
    n_tests++; if (l1_overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0000", l1_overflow); end
    cycle(4'b0100, 64'(16'h2FFF) << 32, 1'b0, 1'b1);
    n_tests++; if (l1_overflow !== 4'b0100) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 0100", l1_overflow); end
    n2 = 0; last2 = -1; guard = 0;
    while (m_total() > 0 && guard < 400) begin
      n_tests++; if (rd_data !== m_head_data() || rd_ch !== m_head_ch()) begin n_fail++; $display("FAIL ovf_drain: got %0d/%h expected %0d/%h", rd_ch, rd_data, m_head_ch(), m_head_data()); end
      if (rd_ch === 2'd2) begin n2++; last2 = int'(rd_data); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
      guard++;
    end
    n_tests++; if (n2 != 16)         begin n_fail++; $display("FAIL ovf_ch2_count: got %0d expected 16", n2); end
    n_tests++; if (last2 != 'h200F)  begin n_fail++; $display("FAIL ovf_ch2_last: got %h expected 200f", last2); end
  endtask

  task automatic test_watermark();
    watermark = 7'd75;
    apply_reset();
    for (int i = 0; i < 102; i++) begin
      cycle(4'b0001, 64'(i), 1'b0, 1'b0);
      n_tests++; if (l2_count !== 8'(m_l2.size())) begin n_fail++; $display("FAIL wm_count: got %0d expected %0d", l2_count, m_l2.size()); end
      n_tests++; if (backpressure !== (m_l2.size() >= 96)) begin n_fail++; $display("FAIL wm75_rise at %0d: got %b expected %b", m_l2.size(), backpressure, m_l2.size() >= 96); end
    end
    repeat (2) cycle(4'b0, 64'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
      n_tests++; if (backpressure !== (m_l2.size() >= 96)) begin n_fail++; $display("FAIL wm75_fall at %0d: got %b expected %b", m_l2.size(), backpressure, m_l2.size() >= 96); end
    end
    watermark = 7'd127;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0001, 64'(i), 1'b0, 1'b0);
      n_tests++; if (backpressure !== (m_l2.size() >= 128)) begin n_fail++; $display("FAIL wm127 at %0d: got %b expected %b", m_l2.size(), backpressure, m_l2.size() >= 128); end
    end
    watermark = 7'd0;
    apply_reset();
    cycle(4'b0, 64'b0, 1'b0, 1'b0);
    n_tests++; if (backpressure !== 1'b1) begin n_fail++; $display("FAIL wm0_empty: got %b expected 1", backpressure); end
    for (int i = 0; i < 6; i++) begin
      cycle(4'(i % 2), 64'(i), 1'(i > 2), 1'b0);
      n_tests++; if (backpressure !== 1'b1) begin n_fail++; $display("FAIL wm0_hold[%0d]: got %b expected 1", i, backpressure); end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int guard;
    logic [63:0] wd;
    watermark = 7'd30;
    apply_reset();
    guard = 0;
    while (m_l2.size() < 50 && guard < 200) begin
      c = guard % 4;
      cycle(4'(1 << c), 64'(16'hD000 | 16'($urandom_range(0, 4095))) << (c * 16), 1'b0, 1'b0);
      guard++;
    end
    repeat (3) cycle(4'hF, {4{16'hDEAD}}, 1'b0, 1'b0);
    n_tests++; if (backpressure !== 1'b1) begin n_fail++; $display("FAIL mid_bp_before: got %b expected 1", backpressure); end
    wr_en = 4'hF; wr_data = {4{16'hDBAD}};
    #2 rst = 1'b1;
    #1;
    n_tests++; if (rd_empty !== 1'b1)     begin n_fail++; $display("FAIL mid_rd_empty: got %b expected 1", rd_empty); end
    n_tests++; if (l2_count !== 8'd0)     begin n_fail++; $display("FAIL mid_l2_count: got %0d expected 0", l2_count); end
    n_tests++; if (rd_data !== 16'h0)     begin n_fail++; $display("FAIL mid_rd_data: got %h expected 0000", rd_data); end
    n_tests++; if (backpressure !== 1'b0) begin n_fail++; $display("FAIL mid_bp: got %b expected 0", backpressure); end
    n_tests++; if (wr_full !== 4'b0)      begin n_fail++; $display("FAIL mid_wr_full: got %b expected 0000", wr_full); end
    n_tests++; if (l1_overflow !== 4'b0)  begin n_fail++; $display("FAIL mid_ovf: got %b expected 0000", l1_overflow); end
    wr_en = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < NCH; k++) wd[k*16 +: 16] = 16'($urandom_range(0, 32767));
      n_tests++; if (rd_data !== m_head_data() || rd_ch !== m_head_ch()) begin n_fail++; $display("FAIL mid_post[%0d]: got %0d/%h expected %0d/%h", i, rd_ch, rd_data, m_head_ch(), m_head_data()); end
      cycle(4'($urandom) & 4'($urandom), wd, 1'($urandom), 1'b0);
    end
    guard = 0;
    while (m_total() > 0 && guard < 200) begin
      n_tests++; if (rd_data !== m_head_data()) begin n_fail++; $display("FAIL mid_drain: got %h expected %h", rd_data, m_head_data()); end
      cycle(4'b0, 64'b0, 1'b1, 1'b0);
      guard++;
    end
    n_tests++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty_end: got %b expected 1", rd_empty); end
  endtask

  task automatic test_random();
    logic [63:0] wd;
    int          rdp;
    watermark = 7'd50;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       rdp = 10;
        1:       rdp = 90;
        default: rdp = 50;
      endcase
      if ($urandom_range(0, 49) == 0) watermark = 7'($urandom_range(0, 127));
      for (int k = 0; k < NCH; k++) wd[k*16 +: 16] = 16'($urandom);
      n_tests++; if (rd_data !== m_head_data() || rd_ch !== m_head_ch()) begin n_fail++; $display("FAIL rnd_head[%0d]: got %0d/%h expected %0d/%h", i, rd_ch, rd_data, m_head_ch(), m_head_data()); end
      cycle(4'($urandom), wd, 1'($urandom_range(0, 99) < rdp), 1'($urandom_range(0, 19) == 0));
      n_tests++;
      if (rd_empty !== (m_l2.size() == 0) || l2_count !== 8'(m_l2.size()) || wr_full !== m_full() ||
          l1_overflow !== m_ovf || backpressure !== m_bp) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: got e%b c%0d f%b o%b bp%b expected e%b c%0d f%b o%b bp%b", i,
                 rd_empty, l2_count, wr_full, l1_overflow, backpressure,
                 m_l2.size() == 0, m_l2.size(), m_full(), m_ovf, m_bp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_l2_full();
    test_overflow();
    test_watermark();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hier_fifo_mc.md
# hier_fifo_mc

Multi-channel, two-level hierarchical FIFO, the parametrised successor of the single-stream hierarchical FIFO system. NUM_CH independent producer channels each write into a private L1 FIFO. A round-robin promotion engine moves one entry per cycle into a shared L2 FIFO, tagging it with its channel ID. A single first-word-fall-through read port drains L2, and a programmable percent watermark on L2 drives backpressure toward the producers.

## Interface
- DATA_WIDTH, 16, payload width per entry
- NUM_CH, 4, producer channel count (≥2)
- L1_DEPTH, 16, per-channel L1 depth (power of 2)
- L2_DEPTH, 128, shared L2 depth (power of 2)
- CH_W, derived $clog2(NUM_CH), channel-tag width (localparam)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  NUM_CH  per-channel write strobe
- wr_data  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- wr_full  out  NUM_CH  per-channel L1 full
- rd_en  in  1  pop L2 head
- rd_data  out  DATA_WIDTH  L2 head payload (FWFT)
- rd_ch  out  CH_W  channel tag of L2 head
- rd_empty  out  1  L2 empty
- watermark  in  7  backpressure threshold, percent of L2_DEPTH; values >100 clamp to 100
- backpressure  out  1  registered L2-occupancy ≥ watermark
- l1_overflow  out  NUM_CH  sticky: write attempted while that L1 was full
- clr_ovf  in  1  clears all l1_overflow bits
- l2_count  out  $clog2(L2_DEPTH)+1  L2 occupancy

## Operation
- L1 write: wr_en[c] & !wr_full[c] pushes wr_data slice c. wr_en[c] & wr_full[c] drops the data and sets l1_overflow[c]. Same-cycle set and clr_ovf: set wins.
- Promotion: each cycle, if L2 count < L2_DEPTH and any L1 is non-empty, grant one channel round-robin. Search starts at last_grant+1 modulo NUM_CH. The granted channel's L1 head is popped and {ch, data} is pushed into L2. last_grant updates only on an actual grant. Reset value of last_grant is NUM_CH-1, so channel 0 has first priority.
- No L2 bypass: L2 full blocks promotion even if rd_en pops in the same cycle.
- Per-channel order is preserved end to end. Inter-channel order follows grant order.
- Read: while !rd_empty, rd_data/rd_ch present the L2 head combinationally. rd_en pops it. rd_en while empty is ignored with no side effect. rd_data and rd_ch are 0 while empty.
- L1 and L2 support simultaneous push and pop on the same cycle. Count is unchanged in that case.
- Backpressure: registered (l2_count_next*100 ≥ wm_clamped*L2_DEPTH). Computed at 32-bit width. watermark=0 asserts backpressure continuously. backpressure is advisory only; writes are never blocked by it.
- Pointers wrap modulo depth. Full/empty are derived from counts.

## Timing
- Reset values: wr_full=0, rd_empty=1, rd_data=0, rd_ch=0, backpressure=0, l1_overflow=0, l2_count=0. All FIFOs empty, last_grant=NUM_CH-1.
- rst mid-operation discards all stored data immediately (async). First write is accepted on the first edge after rst deasserts.
- Write-to-read latency is 2 edges on an idle system:
  - Edge N: L1 push.
  - Edge N+1: promotion.
  - After N+1: rd_empty=0.
- wr_full[c] updates after the push edge that fills L1. l1_overflow updates on the edge of the rejected write.
- Promotion throughput: 1 entry per cycle aggregate. Each of k active channels gets ≥1 grant per k cycles.
- backpressure reflects occupancy after the current edge. No extra lag beyond that register.

## Structure
- Package hier_fifo_mc_pkg holds:
  - the percent compare function (`wm_hit(count, depth, wm)`)
  - the clamp constant WM_MAX=100
  - the L2 entry typedef {ch, data}
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH; ports for push/pop/full/empty/count) is instantiated NUM_CH times as L1 and once as L2 with WIDTH=DATA_WIDTH+CH_W.
- The round-robin arbiter and the watermark/overflow logic stay inline in hier_fifo_mc.

## Test plan
- Reset/basic:
  - Stimulus: after rst, write 20 words 0x0000..0x0013 on ch0; 5-cycle wait; read 20.
  - Required response: outputs are at reset values before the writes; data returned in order, rd_ch=0; rd_empty=1 afterwards; l2_count=0.
- Round-robin fairness:
  - Stimulus: with rd_en held low, preload 4 words into each of ch0..ch3 (ch c data 0xc00..0xc03).
  - Required response: L2 order interleaves ch0,ch1,ch2,ch3 repeating; per-channel data increments; 16 total.
- L2 full / no bypass:
  - Stimulus: L2_DEPTH=128; write 128+16 entries across channels with no reads; then read 1 per cycle.
  - Required response: l2_count saturates at 128 with L1s holding the remainder; each read frees exactly one slot, refilled next edge; total read = all written, no loss.
- Overflow sticky:
  - Stimulus: with promotion stalled (L2 full), write 17 words to ch2 (L1_DEPTH=16).
  - Required response: wr_full[2]=1 after 16; 17th dropped; l1_overflow=4'b0100; clr_ovf clears it; simultaneous overflow and clr_ovf keeps it set.
- Watermark:
  - Stimulus: watermark=75, L2_DEPTH=128.
  - Required response: backpressure rises exactly when l2_count reaches 96 and falls at 95; watermark=127 behaves as 100 (asserts only at 128); watermark=0 keeps it high.
- Reset mid-burst:
  - Stimulus: assert rst while all channels are writing and L2 holds 50 entries.
  - Required response: all outputs return to reset values asynchronously; post-reset traffic returns only post-reset data.
